// File: rtl/event_packer.sv
// Event packer: turns per-unit event-code changes into timestamped 32-bit records.
// The records are queued in a first-word-fall-through FIFO, and unit arbitration is round-robin.
module event_packer #(
  parameter int NUM_UNITS  = 4,
  parameter int TS_WIDTH   = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_in_valid,
  input  logic [2*NUM_UNITS-1:0]        event_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [1:0]          prev      [NUM_UNITS];
  logic [1:0]          pend_code [NUM_UNITS];
  logic [TS_WIDTH-1:0] pend_ts   [NUM_UNITS];
  logic [NUM_UNITS-1:0] pending;
  logic [UNIT_W-1:0]   rr;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  logic [NUM_UNITS-1:0] detect, granted, drop;
  logic                 hi_any, lo_any;
  logic [UNIT_W-1:0]    hi_idx, lo_idx, grant_idx, rr_next;
  logic                 full, push, pop;
  logic [31:0]          grant_rec;
  logic [8:0]           n_drop, drop_sum;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    detect = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      detect[u] = (event_in[2*u +: 2] != 2'b00) && (event_in[2*u +: 2] != prev[u]);
    end
  end

  // The descending scan leaves the lowest pending unit, overall and at/after rr.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (pending[u]) begin
        lo_any = 1'b1;
        lo_idx = UNIT_W'(u);
        if (UNIT_W'(u) >= rr) begin
          hi_any = 1'b1;
          hi_idx = UNIT_W'(u);
        end
      end
    end
  end

  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push      = lo_any && !full;
  assign grant_idx = hi_any ? hi_idx : lo_idx;
  assign rr_next   = (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + UNIT_W'(1);
  assign grant_rec = {24'(pend_ts[grant_idx]), 4'(grant_idx), 2'b00, pend_code[grant_idx]};

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;

  always_comb begin
    granted = '0;
    drop    = '0;
    n_drop  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      granted[u] = push && (grant_idx == UNIT_W'(u));
      drop[u]    = detect[u] && pending[u] && !granted[u];
      if (drop[u]) n_drop = n_drop + 9'd1;
    end
    drop_sum = {1'b0, drop_count} + n_drop;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from start-of-cycle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      rr         <= '0;
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        prev[u]      <= 2'b00;
        pend_code[u] <= 2'b00;
        pend_ts[u]   <= '0;
      end
    end else begin
      if (sample_in_valid) ts <= ts + TS_WIDTH'(1);
      for (int u = 0; u < NUM_UNITS; u++) begin
        prev[u] <= event_in[2*u +: 2];
        if (detect[u]) begin
          pending[u]   <= 1'b1;
          pend_code[u] <= event_in[2*u +: 2];
          pend_ts[u]   <= ts;
        end else if (granted[u]) begin
          pending[u] <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr     <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
    end
  end

  // NOTE: record storage has no reset; emptiness is tracked by fifo_count and out_data is gated by it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_rec;
  end

endmodule

// File: tb/tb_event_packer.sv
// Scoreboarded bench for event_packer: stimulus pushes expected records, a negedge monitor pops and compares.
// A second narrow-timestamp instance covers the timestamp wrap in a short run.
module tb_event_packer;

  logic        clk;
  logic        rst_n;
  logic        sample_in_valid;
  logic [7:0]  event_in;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  logic        w_sample;
  logic [7:0]  w_event;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [3:0]  w_count;
  logic        w_overflow;
  logic [7:0]  w_drops;

  event_packer dut (
    .clk(clk), .rst_n(rst_n), .sample_in_valid(sample_in_valid), .event_in(event_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  event_packer #(.TS_WIDTH(10)) dut_w (
    .clk(clk), .rst_n(rst_n), .sample_in_valid(w_sample), .event_in(w_event),
    .out_ready(w_ready), .out_valid(w_valid), .out_data(w_data),
    .fifo_count(w_count), .overflow(w_overflow), .drop_count(w_drops)
  );

  logic [31:0] exp_q[$];
  int          errors    = 0;
  int          checks    = 0;
  int          rec_count = 0;
  logic [23:0] ts_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rec(input logic [23:0] t, input int u, input logic [1:0] c);
    logic [3:0] uid;
    uid = 4'(u);
    return {t, uid, 2'b00, c};
  endfunction

  // Timestamp model advances on every edge that sees a strobe.
  task automatic tick();
    @(posedge clk);
    if (rst_n && sample_in_valid) ts_model = ts_model + 24'd1;
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    sample_in_valid = 1'b0;
    event_in        = '0;
    w_sample        = 1'b0;
    w_event         = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    ts_model = '0;
    rst_n    = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'b0, (exp_q.size() == 0) && !out_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %h expected none", out_data);
      end else begin
        check("record", out_data, exp_q.pop_front());
      end
      rec_count++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          u;
    int          base;
    logic [1:0]  c;
    logic [23:0] t_last;

    out_ready = 1'b1;
    w_ready   = 1'b1;
    do_reset();

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_fifo_count", {28'b0, fifo_count}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_drop_count", {24'b0, drop_count}, 32'd0);

    // Five strobes, then unit 1 code 1: record at N+2
    sample_in_valid = 1'b1;
    repeat (5) tick();
    sample_in_valid = 1'b0;
    event_in = 8'h04;
    exp_q.push_back(32'h00000511);
    tick();
    event_in = 8'h00;
    check("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    check("lat_n2_data", out_data, 32'h00000511);
    drain("t1_drain", 20);

    // All four units at once, held three cycles
    do_reset();
    out_ready = 1'b1;
    sample_in_valid = 1'b1;
    repeat (3) tick();
    sample_in_valid = 1'b0;
    base = rec_count;
    exp_q.push_back(32'h00000303);
    exp_q.push_back(32'h00000313);
    exp_q.push_back(32'h00000323);
    exp_q.push_back(32'h00000333);
    event_in = 8'hFF;
    tick();
    tick();
    check("rr_count_n2", {28'b0, fifo_count}, 32'd1);
    tick();
    event_in = 8'h00;
    check("rr_count_n3", {28'b0, fifo_count}, 32'd1);
    drain("t2_drain", 20);
    repeat (3) tick();
    check("t2_records", rec_count - base, 32'd4);

    // Twelve spaced events with the output stalled: 8 queued, 4 held pending
    do_reset();
    out_ready = 1'b0;
    sample_in_valid = 1'b1;
    base = rec_count;
    for (int i = 0; i < 12; i++) begin
      u = i % 4;
      c = 2'((i % 3) + 1);
      event_in = 8'({6'b0, c} << (2 * u));
      exp_q.push_back(rec(ts_model, u, c));
      tick();
      event_in = 8'h00;
      tick();
    end
    tick();
    tick();
    check("stall_fifo_count", {28'b0, fifo_count}, 32'd8);
    check("stall_drop_count", {24'b0, drop_count}, 32'd0);
    check("stall_overflow", {31'b0, overflow}, 32'd0);
    check("stall_head", out_data, exp_q[0]);
    repeat (3) tick();
    check("stall_head_stable", out_data, exp_q[0]);
    out_ready = 1'b1;
    drain("t3_drain", 60);
    check("t3_records", rec_count - base, 32'd12);

    // FIFO full, unit 2 re-triggers while pending; then saturate the drop counter
    do_reset();
    out_ready = 1'b0;
    sample_in_valid = 1'b1;
    base = rec_count;
    for (int i = 0; i < 8; i++) begin
      u = i % 2;
      event_in = (u == 0) ? 8'h01 : 8'h04;
      exp_q.push_back(rec(ts_model, u, 2'd1));
      tick();
      event_in = 8'h00;
      tick();
    end
    event_in = 8'h10;
    tick();
    event_in = 8'h20;
    tick();
    event_in = 8'h00;
    tick();
    check("drop_fifo_full", {28'b0, fifo_count}, 32'd8);
    check("drop_count_one", {24'b0, drop_count}, 32'd1);
    check("drop_overflow", {31'b0, overflow}, 32'd1);
    t_last = '0;
    for (int k = 0; k < 300; k++) begin
      event_in = (k % 2 == 0) ? 8'h10 : 8'h20;
      if (k == 299) t_last = ts_model;
      tick();
    end
    event_in = 8'h00;
    tick();
    check("drop_saturate", {24'b0, drop_count}, 32'd255);
    exp_q.push_back(rec(t_last, 2, 2'd2));
    out_ready = 1'b1;
    drain("t4_drain", 40);
    check("t4_records", rec_count - base, 32'd9);

    // Asynchronous reset mid-cycle with five records queued and overflow set
    do_reset();
    out_ready = 1'b0;
    event_in = 8'h05;
    tick();
    event_in = 8'h08;
    tick();
    event_in = 8'h00;
    tick();
    event_in = 8'h10;
    tick();
    event_in = 8'h00;
    tick();
    event_in = 8'hC0;
    tick();
    event_in = 8'h00;
    tick();
    event_in = 8'h01;
    tick();
    event_in = 8'h00;
    tick();
    tick();
    check("pre_rst_count", {28'b0, fifo_count}, 32'd5);
    check("pre_rst_overflow", {31'b0, overflow}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_count", {28'b0, fifo_count}, 32'd0);
    check("async_rst_overflow", {31'b0, overflow}, 32'd0);
    check("async_rst_drops", {24'b0, drop_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Timestamp wrap on the 10-bit instance
    do_reset();
    w_sample = 1'b1;
    repeat (1023) tick();
    w_event = 8'h01;
    tick();
    w_event = 8'h08;
    w_sample = 1'b0;
    tick();
    w_event = 8'h00;
    check("wrap_valid", {31'b0, w_valid}, 32'd1);
    check("wrap_ts_max", w_data, 32'h0003FF01);
    tick();
    check("wrap_ts_zero", w_data, 32'h00000012);
    tick();
    check("wrap_empty", {31'b0, w_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
